// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA raster timing with pixel strobe, syncs, frame pulse and blink
module vga_timing_gen #(
    parameter int H_VISIBLE    = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_VISIBLE    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter int CLK_DIV      = 4,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       valid,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic       clk_bling
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    // Keep both counters at least one bit wide so BLINK_FRAMES=1 still elaborates.
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [FW-1:0] F_LAST   = FW'(BLINK_FRAMES - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0]    V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0]    HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]    HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0]    VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]    VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DW-1:0] div;
    logic [FW-1:0] fcnt;
    logic          running;
    logic          h_wrap;
    logic          v_wrap;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // All outputs are decodes of registered state, so they add no latency.
    assign pix_en      = running && (div == DIV_LAST);
    assign valid       = running && (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hsync       = !(running && (h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vsync       = !(running && (v_cnt >= VS_START) && (v_cnt < VS_END));
    assign frame_start = pix_en && h_wrap && v_wrap;

    // Running flag and free-running clock divider producing the pixel strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running <= 1'b0;
            div     <= '0;
        end else begin
            running <= 1'b1;
            div     <= (div == DIV_LAST) ? '0 : div + DW'(1);
        end
    end

    // Raster position: column advances per pixel, line advances on column wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Frame counter; the blink level flips each time it completes a period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fcnt      <= '0;
            clk_bling <= 1'b0;
        end else if (frame_start) begin
            if (fcnt == F_LAST) begin
                fcnt      <= '0;
                clk_bling <= ~clk_bling;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pix;
        logic [9:0] h;
        logic [9:0] v;
        logic       valid;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       bl;
    } obs_t;

    typedef struct {
        int         n;
        logic       pix;
        logic [9:0] h;
        logic       valid;
    } rel_t;

    logic clk = 1'b0;
    logic rst_d = 1'b0;
    logic rst_s = 1'b0;

    logic       pix_d, valid_d, hs_d, vs_d, fs_d, bl_d;
    logic [9:0] h_d, v_d;
    logic       pix_s, valid_s, hs_s, vs_s, fs_s, bl_s;
    logic [9:0] h_s, v_s;

    int n_cmp = 0;
    int n_bad = 0;
    int kd = 0;
    int ks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen dut_d (
        .clk(clk), .rst_n(rst_d), .pix_en(pix_d), .h_cnt(h_d), .v_cnt(v_d),
        .valid(valid_d), .hsync(hs_d), .vsync(vs_d), .frame_start(fs_d), .clk_bling(bl_d)
    );

    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(4), .BLINK_FRAMES(2)
    ) dut_s (
        .clk(clk), .rst_n(rst_s), .pix_en(pix_s), .h_cnt(h_s), .v_cnt(v_s),
        .valid(valid_s), .hsync(hs_s), .vsync(vs_s), .frame_start(fs_s), .clk_bling(bl_s)
    );

    // Reference: everything follows from k, the number of clock edges seen with reset released.
    function automatic obs_t model(input int k, input int hv, input int hf, input int hsw, input int hb,
                                   input int vv, input int vf, input int vsw, input int vb,
                                   input int d, input int bf);
        obs_t o;
        int ht, vt, p, h, v, fr;
        bit run;
        ht  = hv + hf + hsw + hb;
        vt  = vv + vf + vsw + vb;
        run = (k >= 1);
        p   = k / d;
        h   = p % ht;
        v   = (p / ht) % vt;
        fr  = p / (ht * vt);
        o.pix   = run && (k % d == d - 1);
        o.h     = 10'(h);
        o.v     = 10'(v);
        o.valid = run && (h < hv) && (v < vv);
        o.hs    = !(run && (h >= hv + hf) && (h < hv + hf + hsw));
        o.vs    = !(run && (v >= vv + vf) && (v < vv + vf + vsw));
        o.fs    = o.pix && (h == ht - 1) && (v == vt - 1);
        o.bl    = ((fr / bf) % 2) == 1;
        return o;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        kd <= rst_d ? kd + 1 : 0;
        ks <= rst_s ? ks + 1 : 0;
    end

    // Continuous comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en && n_bad < 40) begin
            cmp("model_default", 64'({pix_d, h_d, v_d, valid_d, hs_d, vs_d, fs_d, bl_d}),
                64'(model(kd, 640, 16, 96, 48, 480, 10, 2, 33, 4, 30)));
            cmp("model_small", 64'({pix_s, h_s, v_s, valid_s, hs_s, vs_s, fs_s, bl_s}),
                64'(model(ks, 4, 1, 1, 1, 2, 1, 1, 1, 4, 2)));
        end
    end

    initial begin
        rel_t rel_tab[7];
        int   n;
        int   vcnt, hs_low, last_fs, last_tog, fs_cnt, tog_cnt;
        bit   wrap_seen, found, prev_bl;
        logic [9:0] prev_h, prev_v;

        rel_tab[0] = '{1, 1'b0, 10'd0, 1'b1};
        rel_tab[1] = '{2, 1'b0, 10'd0, 1'b1};
        rel_tab[2] = '{3, 1'b1, 10'd0, 1'b1};
        rel_tab[3] = '{4, 1'b0, 10'd1, 1'b1};
        rel_tab[4] = '{5, 1'b0, 10'd1, 1'b1};
        rel_tab[5] = '{7, 1'b1, 10'd1, 1'b1};
        rel_tab[6] = '{8, 1'b0, 10'd2, 1'b1};

        // Reset held for 5 cycles: syncs idle high, no visible pixel, no strobe.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_en = 1'b1;
            cmp("rst_hsync", 64'(hs_d), 64'd1);
            cmp("rst_vsync", 64'(vs_d), 64'd1);
            cmp("rst_valid", 64'(valid_d), 64'd0);
            cmp("rst_pix_en", 64'(pix_d), 64'd0);
        end

        // Release and walk the first cycles from the table.
        rst_d = 1'b1;
        rst_s = 1'b1;
        n = 0;
        for (int i = 0; i < 7; i++) begin
            while (n < rel_tab[i].n) begin
                @(negedge clk);
                n++;
            end
            cmp($sformatf("rel_pix_%0d", rel_tab[i].n), 64'(pix_d), 64'(rel_tab[i].pix));
            cmp($sformatf("rel_h_%0d", rel_tab[i].n), 64'(h_d), 64'(rel_tab[i].h));
            cmp($sformatf("rel_valid_%0d", rel_tab[i].n), 64'(valid_d), 64'(rel_tab[i].valid));
        end

        // Line-level behaviour on the default instance, frame/blink periods on the small one.
        vcnt = 0; hs_low = 0; wrap_seen = 0;
        last_fs = -1; last_tog = -1; fs_cnt = 0; tog_cnt = 0;
        prev_h = h_d; prev_v = v_d; prev_bl = bl_s;
        for (int c = 0; c < 6600; c++) begin
            @(negedge clk);
            if (valid_d && v_d == 10'd1) vcnt++;
            if (!hs_d && v_d == 10'd1) hs_low++;
            if (h_d == 10'd0 && v_d == 10'd1 && prev_h == 10'd799 && prev_v == 10'd0) wrap_seen = 1;
            if (fs_s) begin
                if (last_fs >= 0) cmp("fs_period", 64'(c - last_fs), 64'd140);
                last_fs = c;
                fs_cnt++;
            end
            if (bl_s != prev_bl) begin
                if (last_tog >= 0) cmp("blink_period", 64'(c - last_tog), 64'd280);
                last_tog = c;
                tog_cnt++;
            end
            prev_h = h_d; prev_v = v_d; prev_bl = bl_s;
        end
        cmp("valid_line1", 64'(vcnt), 64'd2560);
        cmp("hsync_low_line1", 64'(hs_low), 64'd384);
        cmp("hwrap_vinc", 64'(wrap_seen), 64'd1);
        cmp("fs_seen", 64'(fs_cnt >= 40), 64'd1);
        cmp("blink_seen", 64'(tog_cnt >= 20), 64'd1);

        // Mid-frame reset inside both sync pulses with the blink level high.
        found = 0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            if (bl_s && h_s == 10'd5 && v_s == 10'd3) found = 1;
        end
        cmp("midreset_found", 64'(found), 64'd1);
        rst_s = 1'b0;
        @(negedge clk);
        rst_s = 1'b1;
        cmp("midreset_h", 64'(h_s), 64'd0);
        cmp("midreset_v", 64'(v_s), 64'd0);
        cmp("midreset_bling", 64'(bl_s), 64'd0);
        cmp("midreset_hsync", 64'(hs_s), 64'd1);
        cmp("midreset_vsync", 64'(vs_s), 64'd1);
        cmp("midreset_valid", 64'(valid_s), 64'd0);
        repeat (3) @(negedge clk);
        cmp("restart_pix", 64'(pix_s), 64'd1);
        @(negedge clk);
        cmp("restart_h", 64'(h_s), 64'd1);

        // Random reset pulses; the continuous model check covers the recovery.
        for (int r = 0; r < 20; r++) begin
            repeat ($urandom_range(1, 600)) @(negedge clk);
            rst_s = 1'b0;
            if (r % 5 == 0) rst_d = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst_s = 1'b1;
            rst_d = 1'b1;
        end
        repeat (50) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
